nbody_sequencer: RTL and testbench

Parametrised control sequencer for the n-body accelerator. It replaces the single-lane CALC_ACCEL/UPDATE_POS control with a multi-lane pair scheduler.
- Issues (i,j) pair reads to LANES parallel acceleration pipelines.
- Carries metadata tags through delay lines matched to the external floating-point latencies.
- Sequences the velocity and position write-backs over num_steps leapfrog steps.
- Datapath (RAMs, FP units, accumulators) is external; this block owns addresses, valids and the step handshake.

---
 rtl/nbody_seq_pkg.sv | 29 ++
 rtl/nbody_tag_delay.sv | 36 +++
 rtl/nbody_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_nbody_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbody_seq_pkg.sv
// Shared types for the n-body pair sequencer: FSM state and the tags carried through the latency-matching delay lines.
// Tag fields are sized for the largest supported build (64K bodies, 16 lanes); the top narrows them.
package nbody_seq_pkg;

    localparam int unsigned TAG_AW    = 16;
    localparam int unsigned TAG_LANES = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_DRAIN_V,
        S_POS,
        S_DRAIN_P,
        S_DONE
    } seq_state_t;

    typedef struct packed {
        logic [TAG_AW-1:0]    i_base;
        logic [TAG_LANES-1:0] lane_mask;
        logic [TAG_LANES-1:0] self_mask;
        logic                 first;
        logic                 last;
    } acc_tag_t;

    typedef struct packed {
        logic [TAG_AW-1:0] addr;
    } pos_tag_t;

endpackage

// File: rtl/nbody_tag_delay.sv
// Fixed-depth shift register for a valid strobe plus its tag; tags only move forward, one stage per cycle.
module nbody_tag_delay #(
    parameter int unsigned DEPTH = 1,
    parameter type         tag_t = logic
) (
    input  logic clk,
    input  logic clr_i,
    input  logic valid_i,
    input  tag_t tag_i,
    output logic valid_o,
    output tag_t tag_o
);

    logic valid_q [DEPTH];
    tag_t tag_q   [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                tag_q[k]   <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            tag_q[0]   <= tag_i;
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                tag_q[k]   <= tag_q[k-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/nbody_sequencer.sv
// Multi-lane (i,j) pair scheduler and leapfrog step sequencer for the n-body accelerator.
// Owns addresses, valids and the step handshake; RAMs and FP units live outside.
module nbody_sequencer
    import nbody_seq_pkg::*;
#(
    parameter int unsigned BODIES   = 512,
    parameter int unsigned LANES    = 1,
    parameter int unsigned ACCL_LAT = 99,
    parameter int unsigned ADD_LAT  = 20,
    parameter int unsigned STEP_W   = 16,
    parameter int unsigned BODY_AW  = $clog2(BODIES),
    parameter int unsigned NB_W     = $clog2(BODIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NB_W-1:0]    num_bodies,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic               done_ack,
    output logic               busy,
    output logic               done,
    output logic [STEP_W-1:0]  step_count,
    output logic               half_kick,
    output logic               acc_issue_valid,
    output logic [BODY_AW-1:0] acc_i_base,
    output logic [BODY_AW-1:0] acc_j,
    output logic [LANES-1:0]   acc_lane_mask,
    output logic               res_valid,
    output logic [BODY_AW-1:0] res_i_base,
    output logic [LANES-1:0]   res_lane_mask,
    output logic [LANES-1:0]   res_self_mask,
    output logic               res_first,
    output logic               res_last,
    output logic               vel_wr_valid,
    output logic [BODY_AW-1:0] vel_wr_i_base,
    output logic [LANES-1:0]   vel_wr_mask,
    output logic               pos_rd_valid,
    output logic [BODY_AW-1:0] pos_rd_addr,
    output logic               pos_wr_valid,
    output logic [BODY_AW-1:0] pos_wr_addr
);

    localparam int unsigned DRAIN_V_CYC = ACCL_LAT + ADD_LAT;
    localparam int unsigned CNT_W       = $clog2(DRAIN_V_CYC + 1);
    localparam int unsigned WIDE_W      = NB_W + 1;
    localparam logic [NB_W-1:0]   BODIES_N = NB_W'(BODIES);
    localparam logic [WIDE_W-1:0] LANES_W  = WIDE_W'(LANES);

    // Lane l of a group is live iff ib+l < n, compared one bit wider so ib+LANES never aliases.
    function automatic logic [LANES-1:0] lanes_valid(input logic [WIDE_W-1:0] ib,
                                                     input logic [WIDE_W-1:0] n);
        logic [LANES-1:0] m;
        for (int l = 0; l < LANES; l++) m[l] = (ib + WIDE_W'(l)) < n;
        return m;
    endfunction

    seq_state_t         state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d, half_q, half_d, commit_q, commit_d;
    logic [STEP_W-1:0]  step_q, step_d, steps_q, steps_d;
    logic [NB_W-1:0]    n_q, n_d;
    logic               iss_q, iss_d, prd_v_q, prd_v_d;
    logic [BODY_AW-1:0] ib_q, ib_d, j_q, j_d, prd_addr_q, prd_addr_d;
    logic [LANES-1:0]   mask_q, mask_d, self_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDE_W-1:0]  ib_w, j_w, n_w;
    logic               last_j, last_grp, clr_c;

    assign ib_w     = WIDE_W'(ib_q);
    assign j_w      = WIDE_W'(j_q);
    assign n_w      = WIDE_W'(n_q);
    assign last_j   = (j_w == n_w - WIDE_W'(1));
    assign last_grp = (ib_w + LANES_W) >= n_w;
    assign clr_c    = rst | abort;

    always_comb begin
        for (int l = 0; l < LANES; l++) self_c[l] = mask_q[l] && ((ib_w + WIDE_W'(l)) == j_w);
    end

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        step_d     = step_q;
        steps_d    = steps_q;
        n_d        = n_q;
        ib_d       = ib_q;
        j_d        = j_q;
        mask_d     = mask_q;
        iss_d      = 1'b0;
        prd_v_d    = 1'b0;
        prd_addr_d = prd_addr_q;
        cnt_d      = cnt_q;
        commit_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = num_bodies;
                    steps_d = (num_steps == '0) ? STEP_W'(1) : num_steps;
                    step_d  = '0;
                    if (num_bodies < NB_W'(2) || num_bodies > BODIES_N) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ACCEL;
                        busy_d  = 1'b1;
                        iss_d   = 1'b1;
                        ib_d    = '0;
                        j_d     = '0;
                        mask_d  = lanes_valid('0, WIDE_W'(num_bodies));
                    end
                end
            end
            S_ACCEL: begin
                if (!last_j) begin
                    iss_d = 1'b1;
                    j_d   = j_q + BODY_AW'(1);
                end else if (!last_grp) begin
                    iss_d  = 1'b1;
                    j_d    = '0;
                    ib_d   = BODY_AW'(ib_w + LANES_W);
                    mask_d = lanes_valid(ib_w + LANES_W, n_w);
                end else begin
                    state_d = S_DRAIN_V;
                    cnt_d   = CNT_W'(DRAIN_V_CYC - 1);
                end
            end
            S_DRAIN_V: begin
                if (cnt_q == '0) begin
                    state_d    = S_POS;
                    prd_v_d    = 1'b1;
                    prd_addr_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_POS: begin
                if (WIDE_W'(prd_addr_q) == n_w - WIDE_W'(1)) begin
                    state_d = S_DRAIN_P;
                    cnt_d   = CNT_W'(ADD_LAT);
                end else begin
                    prd_v_d    = 1'b1;
                    prd_addr_d = prd_addr_q + BODY_AW'(1);
                end
            end
            S_DRAIN_P: begin
                // Last drain cycle bumps the step; the following commit cycle decides where to go.
                if (commit_q) begin
                    if (step_q == steps_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ACCEL;
                        iss_d   = 1'b1;
                        ib_d    = '0;
                        j_d     = '0;
                        mask_d  = lanes_valid('0, n_w);
                    end
                end else if (cnt_q == '0) begin
                    step_d   = step_q + STEP_W'(1);
                    commit_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (done_ack) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        half_d = (state_d == S_ACCEL || state_d == S_DRAIN_V) && (step_d == '0);
    end

    always_ff @(posedge clk) begin
        if (clr_c) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            half_q     <= 1'b0;
            commit_q   <= 1'b0;
            step_q     <= '0;
            steps_q    <= '0;
            n_q        <= '0;
            iss_q      <= 1'b0;
            ib_q       <= '0;
            j_q        <= '0;
            mask_q     <= '0;
            prd_v_q    <= 1'b0;
            prd_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            half_q     <= half_d;
            commit_q   <= commit_d;
            step_q     <= step_d;
            steps_q    <= steps_d;
            n_q        <= n_d;
            iss_q      <= iss_d;
            ib_q       <= ib_d;
            j_q        <= j_d;
            mask_q     <= mask_d;
            prd_v_q    <= prd_v_d;
            prd_addr_q <= prd_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    acc_tag_t acc_in, acc_out, vel_in, vel_out;
    pos_tag_t pos_in, pos_out;
    logic     res_v, vel_in_v, vel_v, pos_v;

    // Tags are zeroed when their strobe is low so idle outputs read as zero.
    always_comb begin
        acc_in = '0;
        if (iss_q) begin
            acc_in.i_base    = TAG_AW'(ib_q);
            acc_in.lane_mask = TAG_LANES'(mask_q);
            acc_in.self_mask = TAG_LANES'(self_c);
            acc_in.first     = (j_q == '0);
            acc_in.last      = last_j;
        end
        vel_in = '0;
        if (vel_in_v) begin
            vel_in.i_base    = acc_out.i_base;
            vel_in.lane_mask = acc_out.lane_mask;
        end
        pos_in = '0;
        if (prd_v_q) pos_in.addr = TAG_AW'(prd_addr_q);
    end

    assign vel_in_v = res_v & acc_out.last;

    nbody_tag_delay #(.DEPTH(ACCL_LAT), .tag_t(acc_tag_t)) u_acc_dly (
        .clk(clk), .clr_i(clr_c), .valid_i(iss_q), .tag_i(acc_in), .valid_o(res_v), .tag_o(acc_out)
    );

    nbody_tag_delay #(.DEPTH(ADD_LAT), .tag_t(acc_tag_t)) u_vel_dly (
        .clk(clk), .clr_i(clr_c), .valid_i(vel_in_v), .tag_i(vel_in), .valid_o(vel_v), .tag_o(vel_out)
    );

    // One extra stage covers the position RAM read.
    nbody_tag_delay #(.DEPTH(ADD_LAT + 1), .tag_t(pos_tag_t)) u_pos_dly (
        .clk(clk), .clr_i(clr_c), .valid_i(prd_v_q), .tag_i(pos_in), .valid_o(pos_v), .tag_o(pos_out)
    );

    logic unused_tag_bits;
    assign unused_tag_bits = |{acc_out.i_base >> BODY_AW, acc_out.lane_mask >> LANES,
                               acc_out.self_mask >> LANES, vel_out.i_base >> BODY_AW,
                               vel_out.lane_mask >> LANES, vel_out.self_mask, vel_out.first,
                               vel_out.last, pos_out.addr >> BODY_AW};

    assign busy            = busy_q;
    assign done            = done_q;
    assign step_count      = step_q;
    assign half_kick       = half_q;
    assign acc_issue_valid = iss_q;
    assign acc_i_base      = ib_q;
    assign acc_j           = j_q;
    assign acc_lane_mask   = mask_q;
    assign res_valid       = res_v;
    assign res_i_base      = BODY_AW'(acc_out.i_base);
    assign res_lane_mask   = LANES'(acc_out.lane_mask);
    assign res_self_mask   = LANES'(acc_out.self_mask);
    assign res_first       = acc_out.first;
    assign res_last        = acc_out.last;
    assign vel_wr_valid    = vel_v;
    assign vel_wr_i_base   = BODY_AW'(vel_out.i_base);
    assign vel_wr_mask     = LANES'(vel_out.lane_mask);
    assign pos_rd_valid    = prd_v_q;
    assign pos_rd_addr     = prd_addr_q;
    assign pos_wr_valid    = pos_v;
    assign pos_wr_addr     = BODY_AW'(pos_out.addr);

endmodule

// File: tb/tb_nbody_sequencer.sv
// Directed bench for nbody_sequencer: a 1-lane and a 4-lane instance with short latencies.
module tb_nbody_sequencer;

    localparam int unsigned BODIES = 16;
    localparam int unsigned ACCL   = 3;
    localparam int unsigned ADDL   = 2;
    localparam int unsigned SW     = 8;
    localparam int unsigned AW     = 4;
    localparam int unsigned NW     = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start1, start4, abort, done_ack;
    logic [NW-1:0] num_bodies;
    logic [SW-1:0] num_steps;

    logic          busy1, done1, half1, iss1, res1, first1, last1, velv1, prdv1, pwrv1;
    logic [SW-1:0] step1;
    logic [AW-1:0] ib1, j1, rib1, vib1, prda1, pwra1;
    logic [0:0]    lm1, rlm1, rsm1, vm1;

    logic          busy4, done4, half4, iss4, res4, first4, last4, velv4, prdv4, pwrv4;
    logic [SW-1:0] step4;
    logic [AW-1:0] ib4, j4, rib4, vib4, prda4, pwra4;
    logic [3:0]    lm4, rlm4, rsm4, vm4;

    int checks = 0;
    int errors = 0;

    nbody_sequencer #(.BODIES(BODIES), .LANES(1), .ACCL_LAT(ACCL), .ADD_LAT(ADDL), .STEP_W(SW)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .num_bodies(num_bodies),
        .num_steps(num_steps), .done_ack(done_ack), .busy(busy1), .done(done1),
        .step_count(step1), .half_kick(half1), .acc_issue_valid(iss1), .acc_i_base(ib1),
        .acc_j(j1), .acc_lane_mask(lm1), .res_valid(res1), .res_i_base(rib1),
        .res_lane_mask(rlm1), .res_self_mask(rsm1), .res_first(first1), .res_last(last1),
        .vel_wr_valid(velv1), .vel_wr_i_base(vib1), .vel_wr_mask(vm1), .pos_rd_valid(prdv1),
        .pos_rd_addr(prda1), .pos_wr_valid(pwrv1), .pos_wr_addr(pwra1)
    );

    nbody_sequencer #(.BODIES(BODIES), .LANES(4), .ACCL_LAT(ACCL), .ADD_LAT(ADDL), .STEP_W(SW)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort), .num_bodies(num_bodies),
        .num_steps(num_steps), .done_ack(done_ack), .busy(busy4), .done(done4),
        .step_count(step4), .half_kick(half4), .acc_issue_valid(iss4), .acc_i_base(ib4),
        .acc_j(j4), .acc_lane_mask(lm4), .res_valid(res4), .res_i_base(rib4),
        .res_lane_mask(rlm4), .res_self_mask(rsm4), .res_first(first4), .res_last(last4),
        .vel_wr_valid(velv4), .vel_wr_i_base(vib4), .vel_wr_mask(vm4), .pos_rd_valid(prdv4),
        .pos_rd_addr(prda4), .pos_wr_valid(pwrv4), .pos_wr_addr(pwra4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; abort = 1'b0; done_ack = 1'b0;
        num_bodies = '0; num_steps = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({busy1, done1, step1, half1, iss1, ib1, j1, lm1, res1, rib1, rlm1, rsm1, first1, last1,
             velv1, vib1, vm1, prdv1, prda1, pwrv1, pwra1} !== '0) begin
            errors++; $display("FAIL reset_dut1: busy=%b done=%b step=%0d iss=%b res=%b, want all zero",
                               busy1, done1, step1, iss1, res1);
        end
        checks++;
        if ({busy4, done4, step4, half4, iss4, ib4, j4, lm4, res4, rib4, rlm4, rsm4, first4, last4,
             velv4, vib4, vm4, prdv4, prda4, pwrv4, pwra4} !== '0) begin
            errors++; $display("FAIL reset_dut4: busy=%b done=%b lm=%b iss=%b res=%b, want all zero",
                               busy4, done4, lm4, iss4, res4);
        end
    endtask

    // Runs a full job on the 1-lane instance and checks every output every cycle against the schedule.
    task automatic run_dut1(input int n, input int steps, input int restart_at);
        int se, lat, p0, s, r, q;
        bit ev, eh;
        se  = (steps == 0) ? 1 : steps;
        lat = n * n + ACCL + ADDL + n + ADDL + 2;
        p0  = n * n + ACCL + ADDL;
        num_bodies = NW'(n); num_steps = SW'(steps);
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int c = 0; c < se * lat; c++) begin
            s = c / lat; r = c % lat;
            if (c == restart_at) begin start1 = 1'b1; num_bodies = NW'(n + 1); end
            else if (c == restart_at + 1) begin start1 = 1'b0; num_bodies = NW'(n); end
            ev = r < n * n;
            checks++;
            if (iss1 !== ev || (ev && ({ib1, j1, lm1} !== {AW'(r / n), AW'(r % n), 1'b1}))) begin
                errors++; $display("FAIL issue c=%0d: got v=%b i=%0d j=%0d, want v=%b i=%0d j=%0d",
                                   c, iss1, ib1, j1, ev, r / n, r % n);
            end
            q = r - int'(ACCL);
            ev = q >= 0 && q < n * n;
            checks++;
            if (res1 !== ev || (ev && ({rib1, rlm1, rsm1, first1, last1} !==
                 {AW'(q / n), 1'b1, (q / n) == (q % n), (q % n) == 0, (q % n) == n - 1}))) begin
                errors++; $display("FAIL res c=%0d: got v=%b i=%0d self=%b f=%b l=%b, want v=%b pair %0d",
                                   c, res1, rib1, rsm1, first1, last1, ev, q);
            end
            q = r - int'(ACCL) - int'(ADDL);
            ev = q >= 0 && q < n * n && (q % n) == n - 1;
            checks++;
            if (velv1 !== ev || (ev && ({vib1, vm1} !== {AW'(q / n), 1'b1}))) begin
                errors++; $display("FAIL vel c=%0d: got v=%b i=%0d m=%b, want v=%b i=%0d",
                                   c, velv1, vib1, vm1, ev, q / n);
            end
            ev = r >= p0 && r < p0 + n;
            checks++;
            if (prdv1 !== ev || (ev && prda1 !== AW'(r - p0))) begin
                errors++; $display("FAIL pos_rd c=%0d: got v=%b a=%0d, want v=%b a=%0d",
                                   c, prdv1, prda1, ev, r - p0);
            end
            q = r - p0 - int'(ADDL) - 1;
            ev = q >= 0 && q < n;
            checks++;
            if (pwrv1 !== ev || (ev && pwra1 !== AW'(q))) begin
                errors++; $display("FAIL pos_wr c=%0d: got v=%b a=%0d, want v=%b a=%0d",
                                   c, pwrv1, pwra1, ev, q);
            end
            eh = (s == 0) && (r < p0);
            checks++;
            if ({half1, busy1, done1, step1} !== {eh, 1'b1, 1'b0, SW'((r == lat - 1) ? s + 1 : s)}) begin
                errors++; $display("FAIL status c=%0d: got half=%b busy=%b done=%b step=%0d, want half=%b step=%0d",
                                   c, half1, busy1, done1, step1, eh, (r == lat - 1) ? s + 1 : s);
            end
            tick();
        end
        checks++;
        if ({busy1, done1, step1, half1, iss1} !== {1'b0, 1'b1, SW'(se), 1'b0, 1'b0}) begin
            errors++; $display("FAIL finish n=%0d: got busy=%b done=%b step=%0d, want busy=0 done=1 step=%0d",
                               n, busy1, done1, step1, se);
        end
        repeat (2) begin
            tick();
            checks++;
            if (done1 !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b want 1", done1); end
        end
        done_ack = 1'b1; tick(); done_ack = 1'b0;
        checks++;
        if ({done1, busy1} !== 2'b00) begin
            errors++; $display("FAIL done_ack: got done=%b busy=%b want 0 0", done1, busy1);
        end
    endtask

    task automatic test_basic();
        run_dut1(4, 1, -1);
    endtask

    task automatic test_four_lanes();
        int q, grp, jj;
        logic [3:0] em, es;
        num_bodies = NW'(6); num_steps = SW'(1);
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int c = 0; c < 27; c++) begin
            grp = c / 6; jj = c % 6;
            em = (grp == 0) ? 4'b1111 : 4'b0011;
            checks++;
            if (iss4 !== (c < 12) || (c < 12 && {ib4, j4, lm4} !== {AW'(grp * 4), AW'(jj), em})) begin
                errors++; $display("FAIL issue4 c=%0d: got v=%b i=%0d j=%0d m=%b, want i=%0d j=%0d m=%b",
                                   c, iss4, ib4, j4, lm4, grp * 4, jj, em);
            end
            q = c - int'(ACCL); grp = q / 6; jj = q % 6;
            em = (grp == 0) ? 4'b1111 : 4'b0011;
            if (grp == 0) es = (jj < 4) ? 4'(1 << jj) : 4'b0000;
            else es = (jj == 4) ? 4'b0001 : ((jj == 5) ? 4'b0010 : 4'b0000);
            checks++;
            if (res4 !== (q >= 0 && q < 12) ||
                (q >= 0 && q < 12 && {rib4, rlm4, rsm4} !== {AW'(grp * 4), em, es})) begin
                errors++; $display("FAIL res4 c=%0d: got v=%b i=%0d m=%b self=%b, want i=%0d m=%b self=%b",
                                   c, res4, rib4, rlm4, rsm4, grp * 4, em, es);
            end
            q = c - int'(ACCL) - int'(ADDL);
            em = (q / 6 == 0) ? 4'b1111 : 4'b0011;
            checks++;
            if (velv4 !== (q >= 0 && q < 12 && q % 6 == 5) ||
                (velv4 && {vib4, vm4} !== {AW'((q / 6) * 4), em})) begin
                errors++; $display("FAIL vel4 c=%0d: got v=%b i=%0d m=%b, want i=%0d m=%b",
                                   c, velv4, vib4, vm4, (q / 6) * 4, em);
            end
            tick();
        end
        checks++;
        if ({done4, busy4, step4} !== {1'b1, 1'b0, SW'(1)}) begin
            errors++; $display("FAIL done4: got done=%b busy=%b step=%0d want 1 0 1", done4, busy4, step4);
        end
        done_ack = 1'b1; tick(); done_ack = 1'b0;
    endtask

    task automatic test_multi_step();
        run_dut1(3, 3, -1);
    endtask

    task automatic test_abort();
        num_bodies = NW'(4); num_steps = SW'(1);
        start1 = 1'b1; tick(); start1 = 1'b0;
        repeat (4) tick();
        checks++;
        if ({iss1, ib1, j1} !== {1'b1, AW'(1), AW'(0)}) begin
            errors++; $display("FAIL abort_pre: got v=%b i=%0d j=%0d want 1 1 0", iss1, ib1, j1);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if ({busy1, done1, step1, half1, iss1, res1, velv1, prdv1, pwrv1} !== '0) begin
            errors++; $display("FAIL abort_flush: got busy=%b iss=%b res=%b vel=%b half=%b want all 0",
                               busy1, iss1, res1, velv1, half1);
        end
        repeat (6) begin
            tick();
            checks++;
            if ({res1, velv1, iss1, busy1} !== 4'b0000) begin
                errors++; $display("FAIL abort_stale: got res=%b vel=%b iss=%b busy=%b want 0",
                                   res1, velv1, iss1, busy1);
            end
        end
        run_dut1(2, 1, -1);
    endtask

    task automatic test_handshake();
        run_dut1(2, 1, 2);
        run_dut1(2, 0, -1);
        for (int k = 0; k < 2; k++) begin
            num_bodies = (k == 0) ? NW'(1) : NW'(17); num_steps = SW'(4);
            start1 = 1'b1; tick(); start1 = 1'b0;
            checks++;
            if ({done1, busy1, step1, iss1} !== {1'b1, 1'b0, SW'(0), 1'b0}) begin
                errors++; $display("FAIL bad_n n=%0d: got done=%b busy=%b step=%0d want 1 0 0",
                                   num_bodies, done1, busy1, step1);
            end
            tick();
            checks++;
            if (done1 !== 1'b1) begin errors++; $display("FAIL bad_n_sticky: got %b want 1", done1); end
            done_ack = 1'b1; tick(); done_ack = 1'b0;
            checks++;
            if (done1 !== 1'b0) begin errors++; $display("FAIL bad_n_ack: got %b want 0", done1); end
        end
        num_bodies = NW'(4); num_steps = SW'(1);
        start1 = 1'b1; abort = 1'b1; tick(); start1 = 1'b0; abort = 1'b0;
        repeat (3) begin
            checks++;
            if ({busy1, iss1, done1} !== 3'b000) begin
                errors++; $display("FAIL start_abort: got busy=%b iss=%b done=%b want 0 0 0",
                                   busy1, iss1, done1);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_pos();
        num_bodies = NW'(4); num_steps = SW'(1);
        start1 = 1'b1; tick(); start1 = 1'b0;
        repeat (22) tick();
        checks++;
        if ({prdv1, prda1} !== {1'b1, AW'(1)}) begin
            errors++; $display("FAIL pre_rst_pos: got v=%b a=%0d want 1 1", prdv1, prda1);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({busy1, done1, step1, half1, iss1, ib1, j1, lm1, res1, rib1, rlm1, rsm1, first1, last1,
             velv1, vib1, vm1, prdv1, prda1, pwrv1, pwra1} !== '0) begin
            errors++; $display("FAIL rst_mid_pos: got busy=%b prd=%b pwr=%b a=%0d want all zero",
                               busy1, prdv1, pwrv1, pwra1);
        end
        repeat (6) begin
            tick();
            checks++;
            if ({pwrv1, prdv1, busy1} !== 3'b000) begin
                errors++; $display("FAIL rst_stale_pos: got pwr=%b prd=%b busy=%b want 0",
                                   pwrv1, prdv1, busy1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_four_lanes();
        test_multi_step();
        test_abort();
        test_handshake();
        test_reset_mid_pos();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
